// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: major opcodes and the hazard controller state type.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } hz_state_t;

  // U-type and JAL carry no rs1 field.
  function automatic logic op_uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    return (op == OP_RTYPE || op == OP_BRANCH || op == OP_STORE);
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE);
  endfunction

endpackage

// File: rtl/hz_perf_cnt.sv
// Saturating event counter with synchronous active-high reset.
module hz_perf_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use, redirect, dmem wait and timeout halt.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1Addr,
  input  logic [4:0]       ID_rs2Addr,
  input  logic [6:0]       ID_opCode,
  input  logic [4:0]       EX_rdAddr,
  input  logic [6:0]       EX_opCode,
  input  logic             EX_reg_W_En,
  input  logic             EX_branchTaken,
  input  logic [6:0]       MEM_opCode,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             ID_EX_En,
  output logic             EX_MEM_En,
  output logic             MEM_WB_En,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Flush,
  output logic             PC_Redirect,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT - 1);

  hz_state_t        state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;

  logic halt, ms, rd, lu, act_rd, act_lu;

  assign halt     = (state_q == StHalt);
  assign dmem_req = !rst && !halt && op_is_mem(MEM_opCode);
  assign ms       = dmem_req && !dmem_ready;
  assign rd       = EX_branchTaken || (EX_opCode == OP_JAL) || (EX_opCode == OP_JALR);
  assign lu       = (EX_opCode == OP_LOAD) && EX_reg_W_En && (EX_rdAddr != 5'd0) &&
                    (((EX_rdAddr == ID_rs1Addr) && op_uses_rs1(ID_opCode)) ||
                     ((EX_rdAddr == ID_rs2Addr) && op_uses_rs2(ID_opCode)));

  // A memory stall holds any pending redirect/load-use; a redirect flushes the consumer.
  assign act_rd = !rst && !halt && !ms && rd;
  assign act_lu = !rst && !halt && !ms && !rd && lu;

  always_comb begin
    PC_En        = 1'b1;
    IF_ID_En     = 1'b1;
    ID_EX_En     = 1'b1;
    EX_MEM_En    = 1'b1;
    MEM_WB_En    = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;
    PC_Redirect  = 1'b0;
    if (rst) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_En     = 1'b0;
      EX_MEM_En    = 1'b0;
      MEM_WB_En    = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else if (halt) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_En     = 1'b0;
      EX_MEM_En    = 1'b0;
      MEM_WB_En    = 1'b0;
    end else if (ms) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_En     = 1'b0;
      EX_MEM_En    = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (act_rd) begin
      PC_Redirect  = 1'b1;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
    end else if (act_lu) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_Flush  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      StRun: begin
        if (ms) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
        end else if (wait_q == WaitMax) begin
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StRun;
    endcase
    mem_err_d = mem_err_q || (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q && !rst;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_raw, flush_raw;

  assign stall_inc = ms || act_lu || (halt && !rst);
  assign flush_inc = act_rd;

  hz_perf_cnt #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stall_inc),
    .count_o (stall_raw)
  );

  hz_perf_cnt #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flush_inc),
    .count_o (flush_raw)
  );

  assign stall_cycles = rst ? '0 : stall_raw;
  assign flush_count  = rst ? '0 : flush_raw;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32I core. It sequences the IF/ID/EX/MEM/WB pipeline registers and the PC by generating their enable and flush controls. It resolves three cases that the forwarding unit cannot: load-use hazards, taken branches and jumps, and data-memory wait states. A timeout FSM halts the pipeline when the data memory never answers.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive MEM_WAIT cycles before HALT (≥2)
- CNT_W, 32: width of performance counters
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ID_rs1Addr, ID_rs2Addr  in  5 each  source registers of instruction in ID
- ID_opCode  in  7  opcode in ID
- EX_rdAddr  in  5  destination of instruction in EX
- EX_opCode  in  7  opcode in EX
- EX_reg_W_En  in  1  EX instruction writes rd
- EX_branchTaken  in  1  branch in EX resolved taken
- MEM_opCode  in  7  opcode in MEM
- dmem_ready  in  1  data memory completes the current access this cycle
- dmem_req  out  1  MEM stage holds load (0000011) or store (0100011), state≠HALT
- PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En  out  1 each  register load enables
- IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush  out  1 each  load a bubble (NOP) instead of data
- PC_Redirect  out  1  PC selects EX target
- mem_err  out  1  sticky timeout flag
- stall_cycles, flush_count  out  CNT_W each  perf counters (macro-gated)

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state is RUN.
- Load-use condition (LU): all of the following hold:
  - EX_opCode==0000011, EX_reg_W_En, EX_rdAddr≠0
  - Either (EX_rdAddr==ID_rs1Addr and ID uses rs1) or (EX_rdAddr==ID_rs2Addr and ID uses rs2).
  - "Uses rs1" means every opcode except 0110111, 0010111 and 1101111.
  - "Uses rs2" means opcodes 0110011, 1100011 and 0100011.
- Redirect condition (RD): EX_branchTaken, or EX_opCode ∈ {1101111, 1100111}.
- Memory stall (MS): dmem_req && !dmem_ready.
- Priority is MS > RD > LU > normal.
  - MS: PC_En = IF_ID_En = ID_EX_En = EX_MEM_En = 0; MEM_WB_En=1 with MEM_WB_Flush=1. Pending RD/LU is held, not acted on.
  - RD: PC_Redirect=1, IF_ID_Flush=1, ID_EX_Flush=1, all enables 1. Any concurrent LU is discarded, since its consumer is flushed.
  - LU: PC_En=0, IF_ID_En=0, ID_EX_Flush=1, rest enabled. This inserts exactly one bubble. The following cycle the load sits in MEM, and WB→EX forwarding covers the consumer.
  - Normal: all enables 1, all flushes 0, PC_Redirect=0.
- Transitions:
  - RUN→MEM_WAIT on MS.
  - MEM_WAIT→RUN on dmem_ready. The release cycle applies RD/LU/normal rules combinationally.
  - MEM_WAIT→HALT when the wait counter reaches MEM_TIMEOUT−1 and dmem_ready=0.
  - HALT is left only by rst.
- Wait counter:
  - Cleared on entry to MEM_WAIT and in RUN; +1 per MEM_WAIT cycle.
  - Width $clog2(MEM_TIMEOUT).
- HALT behaviour: all enables 0, all flushes 0, dmem_req=0, mem_err=1.

## Timing
- All controls are combinational from state and inputs, with no added latency. State, counter and mem_err are registered on rising clk.
- While rst=1:
  - All *_En=0.
  - IF_ID_Flush = ID_EX_Flush = MEM_WB_Flush = 1.
  - PC_Redirect = dmem_req = mem_err = 0.
  - Counters are 0.
- Reset mid-MEM_WAIT or in HALT returns to RUN on the next edge.
- A single-cycle MS (dmem_ready arrives the cycle after the request) costs exactly one frozen cycle.
- dmem_ready=1 on the same cycle the counter expires counts as success, not HALT.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on each cycle with MS or LU, or in HALT.
  - flush_count increments on each RD cycle.
  - Both are CNT_W-bit and saturate at all-ones.
- HAZARD_PERF_CNT_EN undefined: counters are not built and the outputs are tied to 0.

## Structure
- Shared package rv32_pkg holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - The state enum typedef hz_state_t.
- One sub-module, hz_perf_cnt: a saturating counter instantiated twice, inside the macro guard.

## Test plan
- LU: lw x5 in EX (EX_rdAddr=5), add x6,x5,x1 in ID → one cycle of PC_En=0, IF_ID_En=0, ID_EX_Flush=1, then normal. With lui x5 in ID instead → no stall.
- RD: EX_branchTaken=1 with LU simultaneously true → PC_Redirect=1, IF_ID_Flush=1, ID_EX_Flush=1, PC_En=1. flush_count +1.
- MS: lw in MEM, dmem_ready low 3 cycles then high → 3 frozen cycles with MEM_WB_Flush=1, release on the 4th. stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready never high → HALT after 4 wait cycles. mem_err=1, all enables 0. rst clears to RUN.
- MS with pending RD: branch taken in EX during store wait → no redirect until dmem_ready, then redirect that cycle.
- Reset mid-MEM_WAIT: rst for 1 cycle → flushes=1, enables=0 during rst, state RUN, counters 0.
